apmu_ibex_fetch_fifo: RTL and testbench
=======================================

Name: apmu_ibex_fetch_fifo

Overview:
- Instruction fetch FIFO between the instruction-memory response path and the static branch predictor / IF stage.
- Buffers word-aligned 32-bit fetch responses and realigns them into one instruction per handshake, 32-bit or compressed, with a halfword-aligned PC.
- Compressed instructions are presented in the low 16 bits.
- Outputs connect directly to the predictor's fetch_rdata_i / fetch_pc_i / fetch_valid_i.

Parameters:
- NUM_REQS, 2, maximum outstanding memory requests; storage depth DEPTH = NUM_REQS + 1 words.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset; one clock; reset is synchronous and active-low
- clear_i  input  1  flush all entries and load a new instruction address (branch/jump/predicted redirect)
- in_addr_i  input  32  redirect target; sampled only when clear_i=1; bit 0 ignored
- in_valid_i  input  1  memory response valid
- in_rdata_i  input  32  word-aligned response data
- in_err_i  input  1  response bus error
- busy_o  output  1  high when occupancy > DEPTH-NUM_REQS-1; requester must not issue a new request
- out_valid_o  output  1  aligned instruction available
- out_ready_i  input  1  consumer accepts instruction
- out_rdata_o  output  32  instruction; compressed occupies [15:0]
- out_addr_o  output  32  PC of the instruction, bit 0 always 0
- out_err_o  output  1  fetch error for this instruction

Behaviour:
- State:
  - DEPTH entries {rdata, err, valid}, kept compacted with entry 0 oldest.
  - instr_addr_q[31:1] holds the current PC.
- Reset (rst_ni=0 at clk edge): all valid=0, rdata/err=0, instr_addr_q=0.
  - Resulting outputs: out_valid_o=0, out_rdata_o=0, out_addr_o=0, out_err_o=0, busy_o=0.
- Outputs are combinational from registered state only. out_addr_o = {instr_addr_q,1'b0}. Zero-latency read: data pushed at edge N is presentable in cycle N+1.
- Compressed detect: low halfword bits [1:0] != 2'b11.
- Aligned PC (addr[1]=0):
  - Instruction = entry0.rdata.
  - out_valid_o = entry0.valid; out_err_o = entry0.err.
- Unaligned PC (addr[1]=1), lower half lo = entry0.rdata[31:16]:
  - Compressed: out_rdata_o = {16'b0, lo}; valid = entry0.valid; err = entry0.err.
  - Uncompressed: out_rdata_o = {entry1.rdata[15:0], lo}.
    - valid = entry0.valid & (entry1.valid | entry0.err).
    - err = entry0.err | (entry1.valid & entry1.err).
- Aligned compressed: out_rdata_o = {entry0.rdata[31:16], entry0.rdata[15:0]}. Upper bits are don't-care for the consumer but are passed through unmodified.
- Pop (out_valid_o & out_ready_i):
  - instr_addr_q advances by 1 halfword if compressed, else 2 (32-bit wrap-around, no saturation).
  - Entry 0 retires unless the instruction was aligned compressed; remaining entries shift down by one.
- Push (in_valid_i & !clear_i): data is written to the first free slot after any same-cycle pop. Push into a full FIFO with a same-cycle pop is legal.
- Overflow: push with no free slot after pop is a protocol violation. Flag with an assertion; state is undefined.
- out_valid_o=1 with out_ready_i=0: outputs held stable until accepted or cleared.
- Clear:
  - clear_i=1 invalidates all entries and sets instr_addr_q = in_addr_i[31:1] at the edge.
  - Same-cycle in_valid_i data is dropped. Same-cycle pop is ignored; clear wins.
  - Outputs in the clear cycle still reflect pre-clear state; the consumer discards them.
- Error: out_err_o asserted with out_valid_o; data content is don't-care. Popping an error instruction behaves as a normal pop.
- Reset mid-operation: reset overrides clear, push and pop in the same cycle.

Decomposition:
- Package apmu_ibex_pkg gains:
  - typedef fetch_fifo_entry_t {rdata[31:0], err, valid};
  - function is_compressed(logic [15:0]).
- No sub-module: realign and shift logic stays inline, within 150-250 lines.

Test Plan:
- Reset, then clear_i with in_addr_i=0x0000_0080; push 0x0041_8193 -> next cycle out_valid_o=1, out_addr_o=0x80, out_rdata_o=0x0041_8193. Pop -> out_valid_o=0 and addr=0x84.
- Clear to 0x100; push 0x4505_0001 (two compressed) -> first out_rdata_o[15:0]=0x0001 at 0x100, entry kept; second 0x4505 at 0x102; entry retired; addr=0x104.
- Clear to 0x202; push 0x0293_xxxx -> out_valid_o=0. Push 0xxxxx_0050 next -> out_rdata_o=0x0050_0293, out_addr_o=0x202. Pop -> addr=0x206, one entry remains.
- Unaligned uncompressed with entry0.err=1 and entry1 absent -> out_valid_o=1, out_err_o=1.
- Fill DEPTH=3 entries with out_ready_i=0 -> busy_o=1 at occupancy 1+. Push+pop same cycle when full -> no loss, order preserved.
- clear_i coincident with in_valid_i and out_ready_i -> pushed word dropped, no pop, next cycle out_valid_o=0 and out_addr_o=new target.

Source files
------------

// File: rtl/apmu_ibex_pkg.sv
// -----------------------------------------------------------------------------
// apmu_ibex_pkg
//   Shared types and helpers for the apmu_ibex instruction fetch path.
//
//   fetch_fifo_entry_t : one buffered memory response word
//                        {rdata[31:0], err, valid}
//   is_compressed()    : RVC detect on a 16-bit parcel; anything whose two
//                        lowest bits are not 2'b11 is a compressed instruction.
// -----------------------------------------------------------------------------
package apmu_ibex_pkg;

  // Width of one fetch response word and of one instruction parcel.
  localparam int unsigned FETCH_WORD_W = 32;
  localparam int unsigned PARCEL_W     = 16;

  typedef struct packed {
    logic [FETCH_WORD_W-1:0] rdata;
    logic                    err;
    logic                    valid;
  } fetch_fifo_entry_t;

  // The whole parcel is passed in so callers can hand over a halfword directly.
  // Masking keeps every input bit referenced while only [1:0] decides the result.
  function automatic logic is_compressed(input logic [PARCEL_W-1:0] parcel);
    return (parcel & 16'h0003) != 16'h0003;
  endfunction

endpackage

// File: rtl/apmu_ibex_fetch_fifo.sv
// -----------------------------------------------------------------------------
// apmu_ibex_fetch_fifo
//   Instruction fetch FIFO between the instruction-memory response path and the
//   static branch predictor / IF stage. Word-aligned 32-bit responses are
//   buffered and realigned into one instruction per handshake (32-bit or
//   compressed) with a halfword-aligned PC. Compressed instructions are
//   presented in out_rdata_o[15:0].
//
// Ports
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   clear_i      flush all entries and load in_addr_i as the new PC
//   in_addr_i    redirect target (bit 0 ignored), sampled when clear_i=1
//   in_valid_i   memory response valid
//   in_rdata_i   word-aligned response data
//   in_err_i     response bus error
//   busy_o       occupancy > DEPTH-NUM_REQS-1; no new request may be issued
//   out_valid_o  aligned instruction available
//   out_ready_i  consumer accepts the instruction
//   out_rdata_o  instruction, compressed in [15:0]
//   out_addr_o   PC of the instruction, bit 0 always 0
//   out_err_o    fetch error for this instruction
//
// Handshake: an instruction transfers on a rising edge where
//   out_valid_o && out_ready_i && !clear_i. While out_valid_o=1 and
//   out_ready_i=0 all out_* signals stay stable until accepted or cleared.
//   The memory side has no back-pressure: in_valid_i is a plain strobe and the
//   requester uses busy_o to avoid ever overflowing the storage.
// -----------------------------------------------------------------------------
module apmu_ibex_fetch_fifo
  import apmu_ibex_pkg::*;
#(
  parameter int NUM_REQS = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [31:0] in_addr_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        busy_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o
);

  localparam int DEPTH = NUM_REQS + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Entry 0 is always the oldest word; valid entries are kept contiguous.
  fetch_fifo_entry_t entries_q [DEPTH];
  fetch_fifo_entry_t entries_d [DEPTH];
  fetch_fifo_entry_t shifted   [DEPTH];

  logic [31:1] instr_addr_q, instr_addr_d;

  logic             unaligned;
  logic [15:0]      lo_half;
  logic             lo_compressed;
  logic             pop;
  logic             push;
  logic             retire;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [CNT_W-1:0] occupancy;

  // Bit 0 of the redirect target has no meaning for a halfword-aligned PC.
  logic unused_in_addr_bit0;
  assign unused_in_addr_bit0 = in_addr_i[0];

  // ---------------------------------------------------------------------------
  // Realignment: outputs depend on registered state only.
  // ---------------------------------------------------------------------------
  always_comb begin
    unaligned     = instr_addr_q[1];
    lo_half       = unaligned ? entries_q[0].rdata[31:16] : entries_q[0].rdata[15:0];
    lo_compressed = is_compressed(lo_half);

    // Aligned PC: the whole of entry 0 is presented, including the untouched
    // upper half when the instruction is compressed.
    out_rdata_o = entries_q[0].rdata;
    out_valid_o = entries_q[0].valid;
    out_err_o   = entries_q[0].err;

    if (unaligned) begin
      if (lo_compressed) begin
        out_rdata_o = {16'h0000, lo_half};
      end else begin
        // A 32-bit instruction straddling two words needs the next word,
        // unless entry 0 already failed: the error is reported without it.
        out_rdata_o = {entries_q[1].rdata[15:0], lo_half};
        out_valid_o = entries_q[0].valid & (entries_q[1].valid | entries_q[0].err);
        out_err_o   = entries_q[0].err | (entries_q[1].valid & entries_q[1].err);
      end
    end
  end

  assign out_addr_o = {instr_addr_q, 1'b0};

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + CNT_W'(entries_q[i].valid);
    end
  end

  assign busy_o = occupancy > CNT_W'(DEPTH - NUM_REQS - 1);

  // ---------------------------------------------------------------------------
  // Pop / push / clear
  // ---------------------------------------------------------------------------
  assign pop  = out_valid_o & out_ready_i & ~clear_i;
  assign push = in_valid_i & ~clear_i;

  // An aligned compressed instruction only consumes the lower half of entry 0;
  // the upper half is still needed, so the word stays put.
  assign retire = pop & (unaligned | ~lo_compressed);

  always_comb begin
    instr_addr_d = instr_addr_q;
    if (pop) begin
      instr_addr_d = instr_addr_q + (lo_compressed ? 31'd1 : 31'd2);
    end

    for (int i = 0; i < DEPTH; i++) begin
      shifted[i] = entries_q[i];
    end
    if (retire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        shifted[i] = entries_q[i+1];
      end
      shifted[DEPTH-1] = '0;
    end

    // Lowest free slot after the pop; descending scan lets the lowest win.
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!shifted[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = shifted[i];
    end
    if (push && free_found) begin
      entries_d[free_idx] = '{rdata: in_rdata_i, err: in_err_i, valid: 1'b1};
    end

    // A redirect wins over any same-cycle push or pop.
    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i] = '0;
      end
      instr_addr_d = in_addr_i[31:1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      instr_addr_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      instr_addr_q <= instr_addr_d;
    end
  end

  // A response arriving with no slot left after the pop is a requester bug.
  overflow_check : assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && !free_found));

endmodule

// File: tb/tb_apmu_ibex_fetch_fifo.sv
module tb_apmu_ibex_fetch_fifo;

  localparam int NUM_REQS = 2;
  localparam int DEPTH    = NUM_REQS + 1;

  logic        clk_i;
  logic        rst_ni;
  logic        clear_i;
  logic [31:0] in_addr_i;
  logic        in_valid_i;
  logic [31:0] in_rdata_i;
  logic        in_err_i;
  logic        busy_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  apmu_ibex_fetch_fifo #(.NUM_REQS(NUM_REQS)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .in_addr_i   (in_addr_i),
    .in_valid_i  (in_valid_i),
    .in_rdata_i  (in_rdata_i),
    .in_err_i    (in_err_i),
    .busy_o      (busy_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_rdata_o (out_rdata_o),
    .out_addr_o  (out_addr_o),
    .out_err_o   (out_err_o)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // ---------------------------------------------------------------------------
  // Reference model: the fetch stream as a queue of halfword parcels
  // {err, parcel} starting at the current PC. A pending skip means the low
  // parcel of the next arriving word lies before the PC and is discarded.
  // ---------------------------------------------------------------------------
  logic [16:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_skip;

  function automatic logic m_compressed(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_pc   = 32'h0;
    m_skip = 1'b0;
  endfunction

  function automatic void model_clear(input logic [31:0] addr);
    exp_q.delete();
    m_pc   = {addr[31:1], 1'b0};
    m_skip = addr[1];
  endfunction

  // Memory words currently holding at least one parcel at or after the PC.
  function automatic int model_words();
    if (exp_q.size() == 0) return 0;
    return (int'(m_pc[1]) + exp_q.size() + 1) / 2;
  endfunction

  function automatic void model_out(output logic ev, output logic [31:0] ed,
                                    output logic [31:0] ea, output logic ee);
    logic [15:0] h0;
    logic [15:0] h1;
    ev = 1'b0;
    ed = 32'h0;
    ee = 1'b0;
    ea = m_pc;
    if (exp_q.size() > 0) begin
      h0 = exp_q[0][15:0];
      h1 = (exp_q.size() > 1) ? exp_q[1][15:0] : 16'h0;
      if (m_compressed(h0)) begin
        ev = 1'b1;
        ee = exp_q[0][16];
        ed = m_pc[1] ? {16'h0, h0} : {h1, h0};
      end else if (exp_q.size() > 1) begin
        ev = 1'b1;
        ee = exp_q[0][16] | exp_q[1][16];
        ed = {h1, h0};
      end else if (exp_q[0][16]) begin
        ev = 1'b1;
        ee = 1'b1;
      end
    end
  endfunction

  function automatic void model_pop();
    int n;
    n = m_compressed(exp_q[0][15:0]) ? 1 : 2;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      else m_skip = 1'b1;
    end
    m_pc = m_pc + 32'(2 * n);
  endfunction

  function automatic void model_push(input logic [31:0] data, input logic er);
    if (m_skip) m_skip = 1'b0;
    else exp_q.push_back({er, data[15:0]});
    exp_q.push_back({er, data[31:16]});
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: called at a falling edge; checks current outputs against the model,
  // applies one cycle of stimulus, returns at the next falling edge.
  // ---------------------------------------------------------------------------
  task automatic drive_cycle(input logic clr, input logic [31:0] addr, input logic vld,
                             input logic [31:0] data, input logic er, input logic rdy);
    logic        ev, ee, do_push;
    logic [31:0] ed, ea;
    model_out(ev, ed, ea, ee);
    check_eq("out_valid", 32'(out_valid_o), 32'(ev));
    check_eq("out_addr", out_addr_o, ea);
    check_eq("busy", 32'(busy_o), 32'(model_words() > DEPTH - NUM_REQS - 1));
    if (ev) check_eq("out_err", 32'(out_err_o), 32'(ee));
    if (ev && !ee) check_eq("out_rdata", out_rdata_o, ed);

    if (clr) model_clear(addr);
    else if (ev && rdy) model_pop();
    do_push = vld && !clr && (model_words() < DEPTH);
    if (do_push) model_push(data, er);

    clear_i     = clr;
    in_addr_i   = addr;
    in_valid_i  = clr ? vld : do_push;
    in_rdata_i  = data;
    in_err_i    = er;
    out_ready_i = rdy;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic push_word(input logic [31:0] data, input logic er, input logic rdy);
    drive_cycle(1'b0, 32'h0, 1'b1, data, er, rdy);
  endtask

  task automatic idle(input logic rdy);
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  task automatic redirect(input logic [31:0] addr);
    drive_cycle(1'b1, addr, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_valid", 32'(out_valid_o), 32'h0);
    check_eq("rst_rdata", out_rdata_o, 32'h0);
    check_eq("rst_addr", out_addr_o, 32'h0);
    check_eq("rst_err", 32'(out_err_o), 32'h0);
    check_eq("rst_busy", 32'(busy_o), 32'h0);
  endtask

  task automatic mid_reset();
    rst_ni      = 1'b0;
    clear_i     = 1'($urandom_range(0, 1));
    in_addr_i   = $urandom;
    in_valid_i  = 1'($urandom_range(0, 1));
    in_rdata_i  = $urandom;
    in_err_i    = 1'b0;
    out_ready_i = 1'($urandom_range(0, 1));
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
    check_reset_outputs();
  endtask

  function automatic logic [15:0] gen_parcel();
    logic [15:0] h;
    h = 16'($urandom_range(0, 65535));
    if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
    else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
    return h;
  endfunction

  task automatic random_cycle();
    logic        clr, vld, er, rdy;
    logic [31:0] addr, data;
    clr = ($urandom_range(0, 15) == 0);
    if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
    else addr = $urandom;
    vld  = 1'($urandom_range(0, 1));
    data = {gen_parcel(), gen_parcel()};
    er   = ($urandom_range(0, 7) == 0);
    rdy  = ($urandom_range(0, 9) < 7);
    drive_cycle(clr, addr, vld, data, er, rdy);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    in_addr_i   = 32'h0;
    in_valid_i  = 1'b0;
    in_rdata_i  = 32'h0;
    in_err_i    = 1'b0;
    out_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    check_reset_outputs();

    // Aligned 32-bit instruction.
    redirect(32'h0000_0080);
    push_word(32'h0041_8193, 1'b0, 1'b0);
    check_eq("tp1_valid", 32'(out_valid_o), 32'h1);
    check_eq("tp1_addr", out_addr_o, 32'h80);
    check_eq("tp1_rdata", out_rdata_o, 32'h0041_8193);
    idle(1'b1);
    check_eq("tp1_pop_valid", 32'(out_valid_o), 32'h0);
    check_eq("tp1_pop_addr", out_addr_o, 32'h84);

    // Two compressed instructions in one word.
    redirect(32'h0000_0100);
    push_word(32'h4505_0001, 1'b0, 1'b0);
    check_eq("tp2_lo", {16'h0, out_rdata_o[15:0]}, 32'h0001);
    check_eq("tp2_addr0", out_addr_o, 32'h100);
    idle(1'b1);
    check_eq("tp2_hi", out_rdata_o, 32'h0000_4505);
    check_eq("tp2_addr1", out_addr_o, 32'h102);
    check_eq("tp2_kept", 32'(busy_o), 32'h1);
    idle(1'b1);
    check_eq("tp2_addr2", out_addr_o, 32'h104);
    check_eq("tp2_empty", 32'(out_valid_o), 32'h0);

    // Unaligned 32-bit instruction straddling two words.
    redirect(32'h0000_0202);
    push_word(32'h0293_1234, 1'b0, 1'b0);
    check_eq("tp3_wait", 32'(out_valid_o), 32'h0);
    push_word(32'hABCD_0050, 1'b0, 1'b0);
    check_eq("tp3_rdata", out_rdata_o, 32'h0050_0293);
    check_eq("tp3_addr", out_addr_o, 32'h202);
    idle(1'b1);
    check_eq("tp3_pop_addr", out_addr_o, 32'h206);
    check_eq("tp3_one_left", 32'(busy_o), 32'h1);

    // Unaligned 32-bit instruction whose first word errored, second absent.
    redirect(32'h0000_0302);
    push_word(32'h0003_0000, 1'b1, 1'b0);
    check_eq("tp4_valid", 32'(out_valid_o), 32'h1);
    check_eq("tp4_err", 32'(out_err_o), 32'h1);
    idle(1'b1);
    check_eq("tp4_pop_addr", out_addr_o, 32'h306);
    push_word(32'h0013_0093, 1'b0, 1'b0);
    idle(1'b0);

    // Fill to DEPTH, then push and pop in the same cycle.
    redirect(32'h0000_0400);
    push_word(32'h1111_0013, 1'b0, 1'b0);
    check_eq("tp5_busy1", 32'(busy_o), 32'h1);
    push_word(32'h2222_0023, 1'b0, 1'b0);
    push_word(32'h3333_0033, 1'b0, 1'b0);
    push_word(32'h4444_0043, 1'b0, 1'b1);
    check_eq("tp5_order", out_rdata_o, 32'h2222_0023);
    repeat (4) idle(1'b1);

    // Clear coincident with a response and a consumer accept.
    push_word(32'h5555_0053, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h0000_0500, 1'b1, 32'h6666_0063, 1'b0, 1'b1);
    check_eq("tp6_valid", 32'(out_valid_o), 32'h0);
    check_eq("tp6_addr", out_addr_o, 32'h500);
    check_eq("tp6_busy", 32'(busy_o), 32'h0);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) mid_reset();
      else random_cycle();
    end
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
